// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control FSM with memory wait counter
// Optional jump state compiled in with `define MULTICYCLE_JUMP_EN.
module multicycle_control #(
    parameter int OPW     = 6,
    parameter int MEM_LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    output logic           PCWrite,
    output logic           PCWriteCond,
    output logic           IorD,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           IRWrite,
    output logic           MemtoReg,
    output logic           RegDst,
    output logic           RegWrite,
    output logic           ALUSrcA,
    output logic [1:0]     ALUSrcB,
    output logic [1:0]     ALUOp,
    output logic [1:0]     PCSource,
    output logic           LoadHalf,
    output logic           LoadUnsigned,
    output logic           illegal,
    output logic [3:0]     state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        IEXEC  = 4'd9,
        IWB    = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [3:0]     LAST   = 4'(MEM_LAT - 1);
    localparam logic [OPW-1:0] OP_R   = OPW'(32'h00);
    localparam logic [OPW-1:0] OP_LW  = OPW'(32'h23);
    localparam logic [OPW-1:0] OP_SW  = OPW'(32'h2B);
    localparam logic [OPW-1:0] OP_LH  = OPW'(32'h21);
    localparam logic [OPW-1:0] OP_LHU = OPW'(32'h25);
    localparam logic [OPW-1:0] OP_BEQ = OPW'(32'h04);
    localparam logic [OPW-1:0] OP_ADI = OPW'(32'h08);
    localparam logic [OPW-1:0] OP_J   = OPW'(32'h02);

    state_t         st;
    state_t         nst;
    logic [3:0]     wcnt;
    logic [OPW-1:0] op_q;
    logic           wdone;

    assign state = st;
    assign wdone = (wcnt == LAST);

    // Counter restarts on every state change; only the wait states ever hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            st   <= FETCH;
            wcnt <= 4'd0;
            op_q <= '0;
        end else begin
            st   <= nst;
            wcnt <= (nst != st) ? 4'd0 : wcnt + 4'd1;
            if (st == DECODE)
                op_q <= opcode;
        end
    end

    always_comb begin
        nst          = FETCH;
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        MemtoReg     = 1'b0;
        RegDst       = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ALUOp        = 2'b00;
        PCSource     = 2'b00;
        LoadHalf     = 1'b0;
        LoadUnsigned = 1'b0;
        illegal      = 1'b0;
        case (st)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = wdone;
                PCWrite = wdone;
                nst     = wdone ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                if (opcode == OP_R)
                    nst = EXEC;
                else if (opcode == OP_LW || opcode == OP_SW || opcode == OP_LH || opcode == OP_LHU)
                    nst = MEMADR;
                else if (opcode == OP_BEQ)
                    nst = BRANCH;
                else if (opcode == OP_ADI)
                    nst = IEXEC;
`ifdef MULTICYCLE_JUMP_EN
                else if (opcode == OP_J)
                    nst = JUMP;
`endif
                else
                    illegal = 1'b1;
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                nst     = (op_q == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                nst     = wdone ? MEMWB : MEMRD;
            end
            MEMWB: begin
                RegWrite     = 1'b1;
                MemtoReg     = 1'b1;
                LoadHalf     = (op_q == OP_LH) || (op_q == OP_LHU);
                LoadUnsigned = (op_q == OP_LHU);
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                nst      = wdone ? FETCH : MEMWR;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                nst     = RWB;
            end
            RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                nst     = IWB;
            end
            IWB: begin
                RegWrite = 1'b1;
            end
`ifdef MULTICYCLE_JUMP_EN
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
`endif
            default: nst = FETCH;
        endcase
        // An edge with reset high must not commit any architectural write.
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            MemWrite    = 1'b0;
            RegWrite    = 1'b0;
            IRWrite     = 1'b0;
        end
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have a single clock, clk; reset is synchronous and active-high, named reset.
REQ-002 Parameter OPW SHALL default to 6 and set the opcode width.
REQ-003 Parameter MEM_LAT SHALL default to 1 and set the memory wait cycles per access; legal range is 1..15.
REQ-004 Ports, listed as name, direction, width, meaning, SHALL be:
- clk  in  1  clock.
- reset  in  1  synchronous reset.
- opcode  in  OPW  instruction[31:26] from the IR.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load when ALU zero.
- IorD  out  1  0 selects PC as memory address, 1 selects ALUOut.
- MemRead, MemWrite  out  1 each  memory strobes.
- IRWrite  out  1  IR load.
- MemtoReg, RegDst, RegWrite  out  1 each  register-file controls.
- ALUSrcA  out  1  0 selects PC, 1 selects A.
- ALUSrcB  out  2  00 selects B, 01 selects +4, 10 selects sign-extended immediate, 11 selects shifted immediate.
- ALUOp  out  2  00 is add, 01 is sub, 10 is funct decode.
- PCSource  out  2  00 selects ALU, 01 selects ALUOut, 10 selects jump target.
- LoadHalf, LoadUnsigned  out  1 each  load width and extension.
- illegal  out  1  one-cycle pulse on an unknown opcode.
- state  out  4  current state, for debug.

Function
REQ-005 The state encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11.
REQ-006 Outputs SHALL be decoded combinationally from the registered state and the wait counter, and every output not asserted by a state SHALL be 0.
REQ-007 A 4-bit wait counter wcnt SHALL clear on entry to FETCH, MEMRD and MEMWR, and SHALL increment each cycle spent in those states.
REQ-008 FETCH SHALL assert MemRead with IorD=0, ALUSrcA=0, ALUSrcB=01 and ALUOp=00.
REQ-009 FETCH SHALL assert IRWrite and PCWrite only when wcnt==MEM_LAT-1, and SHALL then go to DECODE; otherwise it SHALL hold.
REQ-010 DECODE SHALL assert ALUSrcA=0, ALUSrcB=11 and ALUOp=00, and SHALL branch on opcode:
- 0x00 goes to EXEC.
- 0x23, 0x2B, 0x21 and 0x25 go to MEMADR.
- 0x04 goes to BRANCH.
- 0x08 goes to IEXEC.
- 0x02 goes to JUMP (only when the jump feature is compiled in).
- any other opcode goes to FETCH with illegal=1 for that cycle only.
REQ-011 MEMADR SHALL assert ALUSrcA=1, ALUSrcB=10 and ALUOp=00, and SHALL go to MEMWR for 0x2B and to MEMRD otherwise.
REQ-012 The opcode SHALL be latched in DECODE so that the memory states use the latched value and are not affected by later opcode changes.
REQ-013 MEMRD SHALL assert MemRead with IorD=1, and SHALL go to MEMWB when wcnt==MEM_LAT-1.
REQ-014 MEMWR SHALL assert MemWrite with IorD=1, and SHALL go to FETCH when wcnt==MEM_LAT-1.
REQ-015 MEMWB SHALL assert RegWrite and MemtoReg with RegDst=0, SHALL set LoadHalf=1 for latched opcode 0x21 or 0x25, SHALL set LoadUnsigned=1 for 0x25, and SHALL then go to FETCH.
REQ-016 EXEC SHALL assert ALUSrcA=1, ALUSrcB=00 and ALUOp=10, and SHALL go to RWB.
REQ-017 RWB SHALL assert RegWrite with RegDst=1 and MemtoReg=0, and SHALL go to FETCH.
REQ-018 BRANCH SHALL assert ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1 and PCSource=01, and SHALL go to FETCH.
REQ-019 IEXEC SHALL assert ALUSrcA=1, ALUSrcB=10 and ALUOp=00, and SHALL go to IWB.
REQ-020 IWB SHALL assert RegWrite with RegDst=0 and MemtoReg=0, and SHALL go to FETCH.
REQ-021 Latency with MEM_LAT=1 SHALL be: R-type 4 cycles, lw/lh/lhu 5, sw 4, beq 3, addi 4, j 3.
REQ-022 Each memory state SHALL add MEM_LAT-1 cycles to these latencies.
REQ-023 Any unused state encoding SHALL go to FETCH on the next edge with all outputs 0.

Reset
REQ-024 When reset=1 at a clk edge, state SHALL become FETCH, and wcnt and the latched opcode SHALL become 0, regardless of the current state or counter value.
REQ-025 In the first cycle after reset, outputs SHALL be the FETCH decode with wcnt=0: MemRead=1, ALUSrcB=01, everything else 0 (including IRWrite and PCWrite unless MEM_LAT=1).
REQ-026 A reset asserted mid-access SHALL abort the access, and no RegWrite, MemWrite or PCWrite SHALL occur on that edge.

Configuration
REQ-027 With the macro MULTICYCLE_JUMP_EN defined, opcode 0x02 SHALL go from DECODE to JUMP, which asserts PCWrite=1 with PCSource=10 and then goes to FETCH.
REQ-028 Without MULTICYCLE_JUMP_EN, opcode 0x02 SHALL be treated as illegal, and state 11 SHALL be handled as an unused encoding.

Verification
REQ-029 Reset scenario: reset held 2 cycles mid-MEMRD -> state=0, MemRead=1, RegWrite=0 the next cycle.
REQ-030 R-type scenario: MEM_LAT=1, opcode 0x00 -> states 0,1,6,7,0; RegWrite=1 with RegDst=1 only in state 7.
REQ-031 lhu scenario: MEM_LAT=3, opcode 0x25 -> 9 cycles; IRWrite pulses on cycle 3; MemWB shows LoadHalf=1, LoadUnsigned=1.
REQ-032 Store scenario: MEM_LAT=2, opcode 0x2B -> MemWrite high 2 cycles with IorD=1, then FETCH; RegWrite never asserted.
REQ-033 Illegal scenario: opcode 0x3F -> illegal=1 for exactly 1 cycle in DECODE, then state returns to 0.
REQ-034 Jump scenario: opcode 0x02 -> with MULTICYCLE_JUMP_EN, PCWrite=1 with PCSource=10 in state 11; without it, illegal=1.
